// File: rtl/triad_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : triad_arb_pkg
//  Purpose  : Shared constants, FSM state encoding and helpers for the
//             triad_arbiter block.
//  Revision : 1.0 - initial release
// ============================================================================
package triad_arb_pkg;

  // Width of one sensor_iterations word as produced by triad_manager.
  localparam int ITER_W_DEFAULT         = 102;
  // 2 ms at 12 MHz.
  localparam int TIMEOUT_CYCLES_DEFAULT = 24000;
  // Grant index width; also caps the number of triads at 8.
  localparam int GRANT_W                = 3;
  localparam int MAX_TRIADS             = 1 << GRANT_W;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RELEASE   = 2'd3
  } arb_state_e;

  // One-hot decode of a grant index over the maximum triad count.
  function automatic logic [MAX_TRIADS-1:0] idx_onehot(input logic [GRANT_W-1:0] idx);
    idx_onehot = {{(MAX_TRIADS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage : triad_arb_pkg
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
//  Module   : rr_priority_picker
//  Purpose  : Combinational round-robin picker. Searches the request vector
//             starting at the index after last_grant_i and wraps around; the
//             previous winner has the lowest priority.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_priority_picker
  import triad_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GRANT_W-1:0] last_grant_i,
  output logic [GRANT_W-1:0] winner_o,
  output logic               valid_o
);

  logic [MAX_TRIADS-1:0] req_pad;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    req_pad                = '0;
    req_pad[NUM_REQ-1:0]   = req_i;
    winner_o               = '0;
    valid_o                = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      int                 sum;
      logic [GRANT_W-1:0] idx;
      sum = int'(last_grant_i) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = GRANT_W'(sum);
      if (req_pad[idx]) begin
        winner_o = idx;
        valid_o  = 1'b1;
      end
    end
  end

endmodule : rr_priority_picker
`default_nettype wire

// File: rtl/triad_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : triad_arbiter
//  Purpose  : Shares one serial_transmitter between NUM_TRIADS triad_manager
//             requesters. Round-robin grant, one transfer at a time, with a
//             per-triad mask that blocks re-grant of a stale request level
//             coming from the slower triad clock domain.
//  Options  : TRIAD_ARB_TIMEOUT_EN - watchdog in WAIT_DONE; after
//             TIMEOUT_CYCLES without a done pulse the transfer is released
//             as if done had arrived. Undefined: WAIT_DONE waits forever.
//  Revision : 1.0 - initial release
// ============================================================================
module triad_arbiter
  import triad_arb_pkg::*;
#(
  parameter int NUM_TRIADS     = 4,
  parameter int ITER_W         = ITER_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                         clk_12MHz,
  input  logic                         rst_n,
  input  logic [NUM_TRIADS-1:0]        data_avl_i,
  input  logic [NUM_TRIADS*ITER_W-1:0] sensor_iterations_i,
  output logic [NUM_TRIADS-1:0]        reset_parser_o,
  output logic                         data_avl_o,
  output logic [ITER_W-1:0]            sensor_iterations_o,
  input  logic                         reset_parser_i,
  output logic [GRANT_W-1:0]           grant_id_o
);

  arb_state_e                state_q, state_d;
  logic [GRANT_W-1:0]        pick_q, pick_d;
  logic [GRANT_W-1:0]        grant_q, grant_d;
  logic [GRANT_W-1:0]        last_grant_q, last_grant_d;
  logic [NUM_TRIADS-1:0]     mask_q, mask_d;
  logic [NUM_TRIADS-1:0]     reset_parser_q, reset_parser_d;
  logic                      data_avl_q, data_avl_d;
  logic [ITER_W-1:0]         sensor_q, sensor_d;

  logic [GRANT_W-1:0]        winner;
  logic                      winner_valid;
  logic [MAX_TRIADS-1:0]     grant_oh;
  logic                      tmo_hit;
  logic [ITER_W-1:0]         words [MAX_TRIADS];

  // Unflatten the word bus; unused slots read as zero.
  for (genvar k = 0; k < MAX_TRIADS; k++) begin : g_word
    if (k < NUM_TRIADS) begin : g_used
      assign words[k] = sensor_iterations_i[k*ITER_W +: ITER_W];
    end else begin : g_unused
      assign words[k] = '0;
    end
  end

  rr_priority_picker #(
    .NUM_REQ      (NUM_TRIADS)
  ) u_picker (
    .req_i        (data_avl_i & ~mask_q),
    .last_grant_i (last_grant_q),
    .winner_o     (winner),
    .valid_o      (winner_valid)
  );

  assign grant_oh = idx_onehot(grant_q);

`ifdef TRIAD_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Count cycles spent in WAIT_DONE; fires on the last allowed cycle.
  always_comb begin
    tmo_cnt_d = '0;
    tmo_hit   = 1'b0;
    if (state_q == ST_WAIT_DONE) begin
      if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) tmo_hit = 1'b1;
      else                                         tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk_12MHz or negedge rst_n) begin
    if (!rst_n) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state and registered-output logic. The word is loaded one cycle
  // before data_avl_o rises so the transmitter always sees a settled word.
  always_comb begin
    state_d        = state_q;
    pick_d         = pick_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    sensor_d       = sensor_q;
    data_avl_d     = data_avl_q;
    reset_parser_d = '0;
    // A mask bit only drops once its request is seen low.
    mask_d         = mask_q & data_avl_i;
    case (state_q)
      ST_IDLE: begin
        if (winner_valid) begin
          pick_d  = winner;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sensor_d = words[pick_q];
        grant_d  = pick_q;
        state_d  = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (reset_parser_i || tmo_hit) begin
          data_avl_d     = 1'b0;
          reset_parser_d = grant_oh[NUM_TRIADS-1:0];
          state_d        = ST_RELEASE;
        end else begin
          data_avl_d     = 1'b1;
        end
      end
      ST_RELEASE: begin
        mask_d       = mask_d | grant_oh[NUM_TRIADS-1:0];
        last_grant_d = grant_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any transfer without a release.
  always_ff @(posedge clk_12MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      pick_q         <= '0;
      grant_q        <= '0;
      last_grant_q   <= GRANT_W'(NUM_TRIADS - 1);
      mask_q         <= '0;
      reset_parser_q <= '0;
      data_avl_q     <= 1'b0;
      sensor_q       <= '0;
    end else begin
      state_q        <= state_d;
      pick_q         <= pick_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      mask_q         <= mask_d;
      reset_parser_q <= reset_parser_d;
      data_avl_q     <= data_avl_d;
      sensor_q       <= sensor_d;
    end
  end

  assign reset_parser_o      = reset_parser_q;
  assign data_avl_o          = data_avl_q;
  assign sensor_iterations_o = sensor_q;
  assign grant_id_o          = grant_q;

endmodule : triad_arbiter
`default_nettype wire

// File: tb/tb_triad_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_triad_arbiter
//  Purpose  : Directed self-checking bench for triad_arbiter. Expected
//             grants are queued when requests are raised and popped when the
//             arbiter presents a transfer.
//  Options  : TRIAD_ARB_TIMEOUT_EN selects the watchdog scenario.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_triad_arbiter;

  localparam int N   = 4;
  localparam int W   = 102;
  localparam int TMO = 50;

  typedef struct packed {
    logic [2:0]   id;
    logic [W-1:0] word;
  } exp_t;

  logic             clk_12MHz;
  logic             rst_n;
  logic [N-1:0]     data_avl_i;
  logic [N*W-1:0]   sensor_iterations_i;
  logic [N-1:0]     reset_parser_o;
  logic             data_avl_o;
  logic [W-1:0]     sensor_iterations_o;
  logic             reset_parser_i;
  logic [2:0]       grant_id_o;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  triad_arbiter #(
    .NUM_TRIADS          (N),
    .ITER_W              (W),
    .TIMEOUT_CYCLES      (TMO)
  ) dut (
    .clk_12MHz           (clk_12MHz),
    .rst_n               (rst_n),
    .data_avl_i          (data_avl_i),
    .sensor_iterations_i (sensor_iterations_i),
    .reset_parser_o      (reset_parser_o),
    .data_avl_o          (data_avl_o),
    .sensor_iterations_o (sensor_iterations_o),
    .reset_parser_i      (reset_parser_i),
    .grant_id_o          (grant_id_o)
  );

  initial clk_12MHz = 1'b0;
  always #5 clk_12MHz = ~clk_12MHz;

  function automatic logic [W-1:0] word_of(input int k);
    case (k)
      0:       word_of = {17{6'h2d}};
      1:       word_of = {51{2'b01}};
      2:       word_of = {51{2'b10}};
      default: word_of = {34{3'b110}};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk_12MHz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k);
    exp_t e;
    e.id   = 3'(k);
    e.word = word_of(k);
    sb.push_back(e);
  endtask

  // Wait (bounded) for data_avl_o, then compare against the queued grant.
  task automatic grant_check(input string tag, output int lat, output int id);
    exp_t e;
    lat = 0;
    id  = 0;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_sb: observed empty queue expected an entry", tag);
      return;
    end
    e  = sb.pop_front();
    id = int'(e.id);
    while (data_avl_o !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_avl"},   128'(data_avl_o),          128'(1));
    chk({tag, "_grant"}, 128'(grant_id_o),          128'(e.id));
    chk({tag, "_word"},  128'(sensor_iterations_o), 128'(e.word));
  endtask

  // Transmitter done pulse after `dly` cycles, then check the release pulse.
  task automatic complete(input string tag, input int dly, input bit drop, input int id);
    logic [N-1:0] oh;
    oh = N'(1) << id;
    for (int i = 0; i < dly; i++) tick();
    reset_parser_i = 1'b1;
    tick();
    reset_parser_i = 1'b0;
    chk({tag, "_rp"},     128'(reset_parser_o), 128'(oh));
    chk({tag, "_avllow"}, 128'(data_avl_o),     128'(0));
    if (drop) data_avl_i[id] = 1'b0;
    tick();
    chk({tag, "_rp1cyc"}, 128'(reset_parser_o), 128'(0));
  endtask

  task automatic do_reset(input string tag);
    rst_n          = 1'b0;
    data_avl_i     = '0;
    reset_parser_i = 1'b0;
    sb.delete();
    tick();
    tick();
    chk({tag, "_avl"},   128'(data_avl_o),          128'(0));
    chk({tag, "_rp"},    128'(reset_parser_o),      128'(0));
    chk({tag, "_word"},  128'(sensor_iterations_o), 128'(0));
    chk({tag, "_grant"}, 128'(grant_id_o),          128'(0));
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int lat;
    int id;
    int cnt;

    sensor_iterations_i = {word_of(3), word_of(2), word_of(1), word_of(0)};
    data_avl_i          = '0;
    reset_parser_i      = 1'b0;
    rst_n               = 1'b0;

    // ---- reset state; done pulse with nothing pending is ignored ----
    do_reset("rst0");
    reset_parser_i = 1'b1;
    tick();
    reset_parser_i = 1'b0;
    chk("idle_done_rp",  128'(reset_parser_o), 128'(0));
    chk("idle_done_avl", 128'(data_avl_o),     128'(0));

    // ---- single triad 1, done during LOAD ignored, release at cycle 10 ----
    data_avl_i[1] = 1'b1;
    push(1);
    tick();
    chk("t1_load_avl", 128'(data_avl_o), 128'(0));
    reset_parser_i = 1'b1;
    tick();
    reset_parser_i = 1'b0;
    chk("t1_c2_avl", 128'(data_avl_o), 128'(0));
    grant_check("t1", lat, id);
    chk("t1_latency", 128'(lat), 128'(1));
    complete("t1", 6, 1'b1, 1);

    // ---- all triads request; expected rotation 0,1,2,3,0 ----
    do_reset("rst1");
    data_avl_i = '1;
    for (int k = 0; k < N; k++) push(k);
    push(0);
    for (int t = 0; t < 5; t++) begin
      grant_check("rr", lat, id);
      complete("rr", 5, 1'b1, id);
      tick();
      if (t < 3) data_avl_i[id] = 1'b1;
    end

    // ---- stale level from triad 2 must not be re-granted ----
    do_reset("rst2");
    data_avl_i[2] = 1'b1;
    push(2);
    grant_check("st", lat, id);
    complete("st", 2, 1'b0, 2);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (data_avl_o !== 1'b0 || reset_parser_o !== '0) cnt++;
    end
    chk("stale_regrant_cycles", 128'(cnt), 128'(0));
    data_avl_i[2] = 1'b0;
    tick();
    data_avl_i[2] = 1'b1;
    push(2);
    grant_check("st2", lat, id);
    chk("st2_latency", 128'(lat), 128'(3));
    complete("st2", 1, 1'b1, 2);

    // ---- reset during WAIT_DONE aborts; pending triad re-served ----
    do_reset("rst3");
    data_avl_i[3] = 1'b1;
    push(3);
    grant_check("ab", lat, id);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_avl",   128'(data_avl_o),          128'(0));
    chk("abort_word",  128'(sensor_iterations_o), 128'(0));
    chk("abort_grant", 128'(grant_id_o),          128'(0));
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (reset_parser_o !== '0) cnt++;
    end
    chk("abort_no_rp", 128'(cnt), 128'(0));
    rst_n = 1'b1;
    push(3);
    grant_check("ab2", lat, id);
    chk("ab2_latency", 128'(lat), 128'(3));
    complete("ab2", 2, 1'b1, 3);

    // ---- no done pulse: watchdog or indefinite wait; request drop ignored ----
    do_reset("rst4");
    data_avl_i[0] = 1'b1;
    push(0);
    grant_check("wd", lat, id);
`ifdef TRIAD_ARB_TIMEOUT_EN
    cnt = 0;
    while (reset_parser_o === '0 && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("tmo_cycles", 128'(cnt),            128'(TMO - 1));
    chk("tmo_rp",     128'(reset_parser_o), 128'(4'b0001));
    data_avl_i[0] = 1'b0;
    tick();
    chk("tmo_rp1cyc", 128'(reset_parser_o), 128'(0));
`else
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (i == 500) data_avl_i[0] = 1'b0;
      if (data_avl_o !== 1'b1 || reset_parser_o !== '0) cnt++;
    end
    chk("hold_low_cycles", 128'(cnt),                 128'(0));
    chk("hold_word",       128'(sensor_iterations_o), 128'(word_of(0)));
    complete("hold", 0, 1'b1, 0);
`endif

    chk("sb_drained", 128'(sb.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_triad_arbiter
`default_nettype wire
